// File: rtl/reg_bank.sv
// ============================================================================
// Module      : reg_bank
// Description : 32-entry MIPS register file with two registered, write-first
//               read ports, hardwired $zero and a preset stack pointer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module reg_bank #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int SP_IDX  = 29,
    parameter int SP_INIT = 227
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int          c_DEPTH   = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] c_SP_VAL = DATA_W'(SP_INIT);

    logic [DATA_W-1:0] r_regs [c_DEPTH];
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic              w_wr_valid;
    logic [DATA_W-1:0] w_rd1_next;
    logic [DATA_W-1:0] w_rd2_next;

    assign w_wr_valid = reg_write && (write_reg != '0);

    // Index 0 is never forwarded; a same-cycle write to the read index wins
    // over the stored contents.
    always_comb begin
        w_rd1_next = r_regs[read_reg1];
        w_rd2_next = r_regs[read_reg2];
        if (read_reg1 == '0) begin
            w_rd1_next = '0;
        end else if (w_wr_valid && (write_reg == read_reg1)) begin
            w_rd1_next = write_data;
        end
        if (read_reg2 == '0) begin
            w_rd2_next = '0;
        end else if (w_wr_valid && (write_reg == read_reg2)) begin
            w_rd2_next = write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= (i == SP_IDX) ? c_SP_VAL : '0;
            end
        end else if (w_wr_valid) begin
            r_regs[write_reg] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd1 <= '0;
            r_rd2 <= '0;
        end else if (read_en) begin
            r_rd1 <= w_rd1_next;
            r_rd2 <= w_rd2_next;
        end
    end

    assign read_data1 = r_rd1;
    assign read_data2 = r_rd2;

endmodule

`default_nettype wire

// File: tb/tb_reg_bank.sv
// ============================================================================
// Module      : tb_reg_bank
// Description : Directed self-checking bench for reg_bank.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_reg_bank;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        read_en;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int n_checks = 0;
    int n_fail   = 0;

    reg_bank #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .SP_IDX  (29),
        .SP_INIT (227)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_en    (read_en),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_checks++;
        if (read_data1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rd1: got %h expected %h", read_data1, 32'h0);
        end
        n_checks++;
        if (read_data2 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rd2: got %h expected %h", read_data2, 32'h0);
        end
        reset = 1'b0; read_en = 1'b1; read_reg1 = 5'd29; read_reg2 = 5'd5;
        tick();
        n_checks++;
        if (read_data1 !== 32'd227) begin
            n_fail++;
            $display("FAIL reset_sp: got %h expected %h", read_data1, 32'd227);
        end
        n_checks++;
        if (read_data2 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_r5: got %h expected %h", read_data2, 32'h0);
        end
        read_reg1 = 5'd31; read_reg2 = 5'd1;
        tick();
        n_checks++;
        if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_r31_r1: got %h/%h expected 0/0", read_data1, read_data2);
        end
        read_en = 1'b0;
    endtask

    task automatic test_write_read();
        reg_write = 1'b1; write_reg = 5'd8; write_data = 32'hDEADBEEF;
        tick();
        reg_write = 1'b0; read_en = 1'b1; read_reg1 = 5'd8; read_reg2 = 5'd29;
        tick();
        n_checks++;
        if (read_data1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL wr_rd_r8: got %h expected %h", read_data1, 32'hDEADBEEF);
        end
        n_checks++;
        if (read_data2 !== 32'd227) begin
            n_fail++;
            $display("FAIL wr_rd_sp: got %h expected %h", read_data2, 32'd227);
        end
        read_en = 1'b0;
    endtask

    task automatic test_zero();
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFFFFFF;
        read_en = 1'b1; read_reg1 = 5'd0; read_reg2 = 5'd0;
        tick();
        n_checks++;
        if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_same: got %h/%h expected 0/0", read_data1, read_data2);
        end
        reg_write = 1'b0;
        tick();
        n_checks++;
        if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_next: got %h/%h expected 0/0", read_data1, read_data2);
        end
        read_en = 1'b0;
    endtask

    task automatic test_collision();
        reg_write = 1'b1; write_reg = 5'd31; write_data = 32'h10; read_en = 1'b0;
        tick();
        write_data = 32'h400; read_en = 1'b1; read_reg1 = 5'd31; read_reg2 = 5'd31;
        tick();
        n_checks++;
        if (read_data1 !== 32'h400 || read_data2 !== 32'h400) begin
            n_fail++;
            $display("FAIL coll_both: got %h/%h expected 400/400", read_data1, read_data2);
        end
        reg_write = 1'b0;
        tick();
        n_checks++;
        if (read_data1 !== 32'h400 || read_data2 !== 32'h400) begin
            n_fail++;
            $display("FAIL coll_stored: got %h/%h expected 400/400", read_data1, read_data2);
        end
        // Only port 1 matches the write index.
        reg_write = 1'b1; write_data = 32'h7; read_reg2 = 5'd8;
        tick();
        n_checks++;
        if (read_data1 !== 32'h7 || read_data2 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL coll_port1: got %h/%h expected 7/deadbeef", read_data1, read_data2);
        end
        reg_write = 1'b0; read_en = 1'b0;
    endtask

    task automatic test_hold();
        reg_write = 1'b1; write_reg = 5'd3; write_data = 32'h55;
        tick();
        reg_write = 1'b0; read_en = 1'b1; read_reg1 = 5'd8; read_reg2 = 5'd3;
        tick();
        n_checks++;
        if (read_data2 !== 32'h55) begin
            n_fail++;
            $display("FAIL hold_load: got %h expected %h", read_data2, 32'h55);
        end
        read_en = 1'b0; reg_write = 1'b1; write_reg = 5'd3; write_data = 32'h66;
        tick();
        n_checks++;
        if (read_data2 !== 32'h55 || read_data1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL hold_write: got %h/%h expected deadbeef/55", read_data1, read_data2);
        end
        reg_write = 1'b0;
        tick();
        n_checks++;
        if (read_data2 !== 32'h55) begin
            n_fail++;
            $display("FAIL hold_idle: got %h expected %h", read_data2, 32'h55);
        end
        read_en = 1'b1;
        tick();
        n_checks++;
        if (read_data2 !== 32'h66) begin
            n_fail++;
            $display("FAIL hold_release: got %h expected %h", read_data2, 32'h66);
        end
        read_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        reg_write = 1'b1; write_reg = 5'd10; write_data = 32'hA;
        tick();
        write_reg = 5'd11; write_data = 32'hB;
        read_en = 1'b1; read_reg1 = 5'd10; read_reg2 = 5'd11;
        tick();
        n_checks++;
        if (read_data1 !== 32'hA || read_data2 !== 32'hB) begin
            n_fail++;
            $display("FAIL b2b: got %h/%h expected a/b", read_data1, read_data2);
        end
        reg_write = 1'b0; read_en = 1'b0;
    endtask

    task automatic test_reset_beats_write();
        reg_write = 1'b1; write_reg = 5'd29; write_data = 32'h1000;
        tick();
        reg_write = 1'b0; read_en = 1'b1; read_reg1 = 5'd29; read_reg2 = 5'd8;
        tick();
        n_checks++;
        if (read_data1 !== 32'h1000) begin
            n_fail++;
            $display("FAIL rbw_pre: got %h expected %h", read_data1, 32'h1000);
        end
        reset = 1'b1; reg_write = 1'b1; write_reg = 5'd29; write_data = 32'h2000;
        read_reg2 = 5'd29;
        tick();
        n_checks++;
        if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
            n_fail++;
            $display("FAIL rbw_out: got %h/%h expected 0/0", read_data1, read_data2);
        end
        reset = 1'b0; reg_write = 1'b0; read_reg1 = 5'd29; read_reg2 = 5'd8;
        tick();
        n_checks++;
        if (read_data1 !== 32'd227 || read_data2 !== 32'h0) begin
            n_fail++;
            $display("FAIL rbw_regs: got %h/%h expected e3/0", read_data1, read_data2);
        end
        read_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
        read_en = 1'b0; read_reg1 = '0; read_reg2 = '0;
        #1;
        test_reset();
        test_write_read();
        test_zero();
        test_collision();
        test_hold();
        test_back_to_back();
        test_reset_beats_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- 32-entry general-purpose register file for the multicycle MIPS datapath.
- Consumes the destination index chosen by the write-register select mux (rt, 29, 31 or rd) and the write-back data.
- Sources the A/B operand values on two registered read ports.
- Owns $zero hardwiring, the stack-pointer reset value and read/write collision ordering.

Parameters:
- DATA_W, 32, width of each register and of the data ports
- ADDR_W, 5, register index width (2^ADDR_W entries)
- SP_IDX, 29, index of the stack-pointer register
- SP_INIT, 227, reset value loaded into register SP_IDX

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- reg_write  input  1  write enable for the current cycle
- write_reg  input  ADDR_W  destination index (from the write-register select mux)
- write_data  input  DATA_W  value to write
- read_en  input  1  load enable for both read-output registers
- read_reg1  input  ADDR_W  index for port 1 (rs)
- read_reg2  input  ADDR_W  index for port 2 (rt)
- read_data1  output  DATA_W  registered port-1 value (A)
- read_data2  output  DATA_W  registered port-2 value (B)

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high, sampled only on the rising edge of clk.
  - Reset overrides reg_write and read_en in the same cycle.
  - All registers clear to 0, except register SP_IDX, which loads SP_INIT.
  - read_data1 and read_data2 clear to 0.
  - Asserting reset mid-sequence discards any same-cycle write.
  - The first post-reset edge behaves normally.
- Write:
  - On a rising edge with reset=0, reg_write=1 and write_reg!=0, the register at write_reg takes write_data.
  - Writes to index 0 are silently dropped; register 0 reads 0 at all times.
  - reg_write=0 leaves all registers unchanged.
- Read:
  - On a rising edge with reset=0 and read_en=1, read_data1 and read_data2 load the values at read_reg1 and read_reg2. Latency is 1 cycle from index presentation.
  - read_en=0 holds both outputs at their previous values, independent of any register writes.
- Collision (write-first):
  - If read_en=1, reg_write=1 and write_reg==read_regN!=0 in the same cycle, read_dataN loads write_data, not the old contents.
  - Both ports forward independently; if read_reg1==read_reg2==write_reg, both ports get write_data.
  - Index 0 is never forwarded: reading 0 always loads 0, even when write_reg=0 with reg_write=1.
- Index handling: all 2^ADDR_W indices are valid; no wrap or out-of-range case exists.
- Timing: no combinational path from any input to read_data1/2; outputs change only at clk edges.
- Storage: no internal state beyond the register array and the two output registers.

Test Plan:
- Reset: reset=1 for 1 cycle, then read_en=1 with read_reg1=29, read_reg2=5 → next cycle read_data1=227, read_data2=0.
- Write then read: reg_write=1, write_reg=8, write_data=0xDEADBEEF; next cycle read_en=1, read_reg1=8 → read_data1=0xDEADBEEF one cycle later.
- $zero: reg_write=1, write_reg=0, write_data=0xFFFFFFFF, with read_en=1, read_reg1=0, read_reg2=0 in the same and the following cycle → both ports read 0 both times.
- Collision forwarding: reg 31 = 0x10; same cycle reg_write=1, write_reg=31, write_data=0x400, read_en=1, read_reg1=31, read_reg2=31 → both ports = 0x400 next cycle (not 0x10).
- Hold: load read_data2=0x55 from reg 3, then read_en=0 while writing reg 3 = 0x66 → read_data2 stays 0x55 until read_en=1, then becomes 0x66.
- Reset beats write: reg 29 = 0x1000; assert reset with reg_write=1, write_reg=29, write_data=0x2000 → reg 29 = 227, read_data1/2 = 0 after the edge.
